// File: rtl/calc_if.sv
// Handshake and result bundle between a requester and the BCD calculator.
// The master drives the request fields; the slave returns status and results.
interface calc_if #(
    parameter int DIGITS = 2,
    parameter int OPW    = 7,
    parameter int RW     = 2 * OPW
);
    logic                  start;
    logic [1:0]            op;
    logic [4*DIGITS-1:0]   a_bcd;
    logic [4*DIGITS-1:0]   b_bcd;
    logic                  busy;
    logic                  done;
    logic [RW-1:0]         result;
    logic [OPW-1:0]        rem;
    logic                  neg;
    logic                  err;

    modport master (
        output start, op, a_bcd, b_bcd,
        input  busy, done, result, rem, neg, err
    );

    modport slave (
        input  start, op, a_bcd, b_bcd,
        output busy, done, result, rem, neg, err
    );
endinterface

// File: rtl/calc_engine.sv
// BCD-input calculator: converts two packed-BCD operands to binary, then
// adds, subtracts, multiplies (shift-add) or divides (restoring) them.
module calc_engine #(
    parameter int DIGITS = 2,
    parameter int OPW    = 7,
    parameter int RW     = 2 * OPW
) (
    input logic    clk,
    input logic    rst_n,
    calc_if.slave  bus
);
    localparam int CMAX = (OPW > DIGITS) ? OPW : DIGITS;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, CONV, EXEC, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    logic [4*DIGITS-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [OPW-1:0]      a_q, a_d, b_q, b_d;
    logic [RW-1:0]       mcand_q, mcand_d, prod_q, prod_d;
    logic [OPW-1:0]      part_q, part_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                bad_q, bad_d;
    logic                busy_q, busy_d, done_q, done_d, neg_q, neg_d, err_q, err_d;
    logic [RW-1:0]       result_q, result_d;
    logic [OPW-1:0]      rem_q, rem_d;

    logic [OPW-1:0]      a_conv, b_conv, sub_mag, quot_next;
    logic                sub_neg, div_ok;
    logic [RW-1:0]       prod_step;
    logic [OPW:0]        div_shift, div_trial;

    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    assign a_conv    = a_q * OPW'(10) + {{(OPW-4){1'b0}}, a_sh_q[4*DIGITS-1 -: 4]};
    assign b_conv    = b_q * OPW'(10) + {{(OPW-4){1'b0}}, b_sh_q[4*DIGITS-1 -: 4]};
    assign sub_neg   = (a_q < b_q);
    assign sub_mag   = sub_neg ? (b_q - a_q) : (a_q - b_q);
    assign prod_step = prod_q + (b_q[0] ? mcand_q : '0);
    // Restoring step: a_q holds the dividend bits and fills up with quotient bits.
    assign div_shift = {part_q, a_q[OPW-1]};
    assign div_trial = div_shift - {1'b0, b_q};
    assign div_ok    = ~div_trial[OPW];
    assign quot_next = {a_q[OPW-2:0], div_ok};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        part_d   = part_q;
        cnt_d    = cnt_q;
        bad_d    = bad_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = op_t'(bus.op);
                    a_sh_d  = bus.a_bcd;
                    b_sh_d  = bus.b_bcd;
                    bad_d   = has_bad_digit(bus.a_bcd) | has_bad_digit(bus.b_bcd);
                    a_d     = '0;
                    b_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                a_d    = a_conv;
                b_d    = b_conv;
                a_sh_d = a_sh_q << 4;
                b_sh_d = b_sh_q << 4;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(DIGITS - 1)) begin
                    cnt_d   = '0;
                    prod_d  = '0;
                    part_d  = '0;
                    mcand_d = {{(RW-OPW){1'b0}}, a_conv};
                    state_d = EXEC;
                    if (bad_q || (op_q == OP_DIV && b_conv == '0)) begin
                        result_d = '0;
                        rem_d    = '0;
                        neg_d    = 1'b0;
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            EXEC: begin
                rem_d = '0;
                neg_d = 1'b0;
                err_d = 1'b0;
                case (op_q)
                    OP_ADD: begin
                        result_d = {{(RW-OPW){1'b0}}, a_q} + {{(RW-OPW){1'b0}}, b_q};
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                    OP_SUB: begin
                        result_d = {{(RW-OPW){1'b0}}, sub_mag};
                        neg_d    = sub_neg;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                    OP_MUL: begin
                        prod_d  = prod_step;
                        mcand_d = mcand_q << 1;
                        b_d     = b_q >> 1;
                        cnt_d   = cnt_q + CW'(1);
                        if (cnt_q == CW'(OPW - 1)) begin
                            result_d = prod_step;
                            done_d   = 1'b1;
                            state_d  = DONE;
                        end else begin
                            result_d = result_q;
                        end
                    end
                    default: begin
                        part_d = div_ok ? div_trial[OPW-1:0] : div_shift[OPW-1:0];
                        a_d    = quot_next;
                        cnt_d  = cnt_q + CW'(1);
                        if (cnt_q == CW'(OPW - 1)) begin
                            result_d = {{(RW-OPW){1'b0}}, quot_next};
                            rem_d    = div_ok ? div_trial[OPW-1:0] : div_shift[OPW-1:0];
                            done_d   = 1'b1;
                            state_d  = DONE;
                        end
                    end
                endcase
                // Outputs only change on DONE entry; hold them while still iterating.
                if (state_d != DONE) begin
                    rem_d = rem_q;
                    neg_d = neg_q;
                    err_d = err_q;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            part_q   <= '0;
            cnt_q    <= '0;
            bad_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            part_q   <= part_d;
            cnt_q    <= cnt_d;
            bad_q    <= bad_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rem    = rem_q;
    assign bus.neg    = neg_q;
    assign bus.err    = err_q;
endmodule
